// File: rtl/tdm_num_detector.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tdm_num_detector
//  Purpose  : Measures the I2S/TDM frame length in BCLK cycles by oversampling
//             the external BCLK/LRCK pins. It reports the frame length as a
//             slot-count code (1=2, 2=4, 3=8, 4=16 slots) once enough
//             consecutive identical frames have been seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_num_detector #(
  parameter int SLOT_BITS   = 32,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2s_bclk,
  input  logic       i2s_lrck,
  input  logic       enable,
  output logic [3:0] tdm_num,
  output logic       locked,
  output logic       update,
  output logic       err
);

  // Frame lengths (in BCLK cycles) that map to a legal slot code.
  localparam logic [9:0] c_LEN_2   = 10'(2 * SLOT_BITS);
  localparam logic [9:0] c_LEN_4   = 10'(4 * SLOT_BITS);
  localparam logic [9:0] c_LEN_8   = 10'(8 * SLOT_BITS);
  localparam logic [9:0] c_LEN_16  = 10'(16 * SLOT_BITS);
  localparam logic [9:0] c_CNT_MAX = 10'd1023;
  localparam logic [3:0] c_LOCK    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t     r_state;

  logic       r_bclk_s1;
  logic       r_bclk_s2;
  logic       r_bclk_d;
  logic       r_lrck_s1;
  logic       r_lrck_s2;
  logic       r_lr_prev;

  logic [9:0] r_bit_cnt;
  logic [3:0] r_cand;
  logic [3:0] r_match_cnt;

  logic       w_bclk_rise;
  logic       w_frame_start;
  logic [3:0] w_code;
  logic       w_code_valid;
  logic [3:0] w_match_next;

  // Pin synchronizers, BCLK edge-detect flop and the per-BCLK LRCK sample.
  // These keep running while disabled so that re-enabling sees a true LRCK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_bclk_s1 <= i2s_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lrck_s1 <= i2s_lrck;
      r_lrck_s2 <= r_lrck_s1;
      if (w_bclk_rise) begin
        r_lr_prev <= r_lrck_s2;
      end
    end
  end

  assign w_bclk_rise   = r_bclk_s2 & ~r_bclk_d;
  assign w_frame_start = w_bclk_rise & r_lrck_s2 & ~r_lr_prev;

  // Classify the length of the frame that just ended; the count is read before
  // it restarts, so r_bit_cnt is the completed frame length here.
  always_comb begin
    w_code       = 4'd0;
    w_code_valid = 1'b0;
    if (r_bit_cnt == c_LEN_2) begin
      w_code       = 4'd1;
      w_code_valid = 1'b1;
    end else if (r_bit_cnt == c_LEN_4) begin
      w_code       = 4'd2;
      w_code_valid = 1'b1;
    end else if (r_bit_cnt == c_LEN_8) begin
      w_code       = 4'd3;
      w_code_valid = 1'b1;
    end else if (r_bit_cnt == c_LEN_16) begin
      w_code       = 4'd4;
      w_code_valid = 1'b1;
    end
  end

  // Run length of identical codes, saturating at the lock threshold.
  // r_cand resets to 0, which never equals a legal code.
  always_comb begin
    w_match_next = 4'd1;
    if (w_code == r_cand) begin
      w_match_next = (r_match_cnt >= c_LOCK) ? c_LOCK : (r_match_cnt + 4'd1);
    end
  end

  // Detector FSM with frame counter and registered result/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 10'd0;
      r_cand      <= 4'd0;
      r_match_cnt <= 4'd0;
      tdm_num     <= 4'd1;
      locked      <= 1'b0;
      update      <= 1'b0;
      err         <= 1'b0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (!enable) begin
        // Disable wins over any frame_start in the same cycle; the last
        // reported code is kept for software to read.
        r_state     <= S_IDLE;
        r_bit_cnt   <= 10'd0;
        r_cand      <= 4'd0;
        r_match_cnt <= 4'd0;
        locked      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SEARCH;
          end

          S_SEARCH: begin
            // The first frame start has no known predecessor; it only aligns the counter.
            if (w_frame_start) begin
              r_bit_cnt <= 10'd1;
              r_state   <= S_MEASURE;
            end else if (w_bclk_rise && (r_bit_cnt != c_CNT_MAX)) begin
              r_bit_cnt <= r_bit_cnt + 10'd1;
            end
          end

          S_MEASURE: begin
            if (w_frame_start) begin
              r_bit_cnt <= 10'd1;
              if (w_code_valid) begin
                r_cand      <= w_code;
                r_match_cnt <= w_match_next;
                // Re-confirming the same code while locked is silent; a new
                // code or a relock after loss reports once.
                if ((w_match_next == c_LOCK) && (!locked || (w_code != tdm_num))) begin
                  tdm_num <= w_code;
                  locked  <= 1'b1;
                  update  <= 1'b1;
                end
              end else begin
                err         <= 1'b1;
                locked      <= 1'b0;
                r_match_cnt <= 4'd0;
              end
            end else if (r_bit_cnt == c_CNT_MAX) begin
              // LRCK has stopped; the counter stays saturated in SEARCH so
              // the timeout fires only once.
              err         <= 1'b1;
              locked      <= 1'b0;
              r_match_cnt <= 4'd0;
              r_state     <= S_SEARCH;
            end else if (w_bclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 10'd1;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_num_detector.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_num_detector
//  Purpose  : Self-checking bench for tdm_num_detector. It applies a table of
//             directed frames, hand sequences for timeout, reset and disable,
//             and randomized frames compared against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_num_detector;

  localparam int SLOT_BITS   = 32;
  localparam int LOCK_FRAMES = 2;
  localparam int BH          = 21;   // BCLK half period (ns); clk is 10 ns

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       i2s_bclk = 1'b0;
  logic       i2s_lrck = 1'b0;
  logic       enable   = 1'b0;
  logic [3:0] tdm_num;
  logic       locked;
  logic       update;
  logic       err;

  int n_vec   = 0;
  int n_fail  = 0;
  int cnt_upd = 0;
  int cnt_err = 0;

  tdm_num_detector #(
    .SLOT_BITS   (SLOT_BITS),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .enable   (enable),
    .tdm_num  (tdm_num),
    .locked   (locked),
    .update   (update),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs; a stretched pulse over-counts.
  always @(negedge clk) begin
    if (update) cnt_upd++;
    if (err)    cnt_err++;
    if (update && err) begin
      n_fail++;
      $display("FAIL pulse_overlap: update=%0d err=%0d, required never both high", update, err);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- frame-level reference model ----------------
  int m_state;        // 0 disabled, 1 waiting for first frame, 2 measuring
  int m_bits;
  bit m_prev_lr;
  int m_tdm;
  bit m_locked;
  int m_upd = 0;
  int m_err = 0;
  int m_codes[$];     // valid codes seen since the last loss of tracking

  function automatic int classify(input int len);
    for (int k = 1; k <= 4; k++) begin
      if (len == (SLOT_BITS << k)) return k;
    end
    return 0;
  endfunction

  task automatic model_frame(input int len);
    int code;
    int run;
    code = classify(len);
    if (code == 0) begin
      m_err++;
      m_locked = 1'b0;
      m_codes.delete();
    end else begin
      m_codes.push_back(code);
      run = 0;
      for (int i = m_codes.size() - 1; i >= 0; i--) begin
        if (m_codes[i] != code) break;
        run++;
      end
      if ((run >= LOCK_FRAMES) && (!m_locked || (code != m_tdm))) begin
        m_tdm    = code;
        m_locked = 1'b1;
        m_upd++;
      end
    end
  endtask

  task automatic model_rise(input bit lr);
    bit start;
    start     = lr && !m_prev_lr;
    m_prev_lr = lr;
    if (m_state == 1) begin
      if (start) begin
        m_state = 2;
        m_bits  = 1;
      end else if (m_bits < 1023) begin
        m_bits++;
      end
    end else if (m_state == 2) begin
      if (start) begin
        model_frame(m_bits);
        m_bits = 1;
      end else begin
        if (m_bits < 1023) m_bits++;
        if (m_bits == 1023) begin
          m_err++;
          m_locked = 1'b0;
          m_codes.delete();
          m_state  = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_state   = enable ? 1 : 0;
    m_bits    = 0;
    m_prev_lr = 1'b0;
    m_tdm     = 1;
    m_locked  = 1'b0;
    m_codes.delete();
  endtask

  task automatic set_enable(input bit v);
    enable = v;
    if (!v) begin
      m_state  = 0;
      m_bits   = 0;
      m_locked = 1'b0;
      m_codes.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_bit(input bit lr);
    i2s_bclk = 1'b0;
    i2s_lrck = lr;
    #BH;
    i2s_bclk = 1'b1;
    model_rise(lr);
    #BH;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) drive_bit(i < len / 2);
  endtask

  // Frame whose start edge coincides with enable being dropped: the BCLK edge
  // is placed on a known clk phase so the rise is processed at the third
  // posedge, and enable goes low just before it.
  task automatic send_frame_disable(input int len);
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b1;
    #BH;
    @(negedge clk);
    i2s_bclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    set_enable(1'b0);
    model_rise(1'b1);
    #BH;
    for (int i = 1; i < len; i++) drive_bit(i < len / 2);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " tdm_num"}, int'(tdm_num), m_tdm);
    check({tag, " locked"},  int'(locked),  int'(m_locked));
    check({tag, " updates"}, cnt_upd,       m_upd);
    check({tag, " errors"},  cnt_err,       m_err);
  endtask

  typedef struct {
    int len;
    int tdm;
    int lk;
    int upd;
    int er;
  } vec_t;

  vec_t tbl[$];
  int   lens[6] = '{64, 128, 256, 48, 96, 160};

  initial begin
    int len;

    // Directed table: each row is one frame; expectations are totals after it.
    tbl.push_back('{256, 1, 0, 0, 0});
    tbl.push_back('{256, 1, 0, 0, 0});
    tbl.push_back('{256, 3, 1, 1, 0});
    for (int i = 0; i < 10; i++) tbl.push_back('{256, 3, 1, 1, 0});
    tbl.push_back('{512, 3, 1, 1, 0});
    tbl.push_back('{512, 3, 1, 1, 0});
    tbl.push_back('{512, 4, 1, 2, 0});
    tbl.push_back('{256, 4, 1, 2, 0});
    tbl.push_back('{256, 4, 1, 2, 0});
    tbl.push_back('{256, 3, 1, 3, 0});
    tbl.push_back('{100, 3, 1, 3, 0});
    tbl.push_back('{256, 3, 0, 3, 1});
    tbl.push_back('{256, 3, 0, 3, 1});
    tbl.push_back('{256, 3, 1, 4, 1});

    // Reset state
    model_reset();
    repeat (5) @(negedge clk);
    check("reset tdm_num", int'(tdm_num), 1);
    check("reset locked",  int'(locked),  0);
    check("reset update",  int'(update),  0);
    check("reset err",     int'(err),     0);
    rst_n = 1'b1;
    model_reset();
    set_enable(1'b1);
    @(negedge clk);

    foreach (tbl[i]) begin
      send_frame(tbl[i].len);
      check($sformatf("row%0d tdm_num", i), int'(tdm_num), tbl[i].tdm);
      check($sformatf("row%0d locked", i),  int'(locked),  tbl[i].lk);
      check($sformatf("row%0d updates", i), cnt_upd,       tbl[i].upd);
      check($sformatf("row%0d errors", i),  cnt_err,       tbl[i].er);
    end

    // LRCK stops while BCLK keeps running
    for (int i = 0; i < 900; i++) drive_bit(1'b0);
    check("timeout err", cnt_err, 2);
    check("timeout locked", int'(locked), 0);
    check("timeout tdm_num", int'(tdm_num), 3);
    for (int i = 0; i < 300; i++) drive_bit(1'b0);
    check("timeout single err", cnt_err, 2);
    for (int i = 0; i < 3; i++) begin
      send_frame(256);
      check_model($sformatf("resume%0d", i));
    end
    check("resume updates", cnt_upd, 5);
    for (int i = 0; i < 3; i++) begin
      send_frame(512);
      check_model($sformatf("to16_%0d", i));
    end
    check("locked at 4", int'(tdm_num), 4);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 100; i++) drive_bit(i < 256);
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    #BH;
    rst_n = 1'b0;
    #1;
    check("async rst tdm_num", int'(tdm_num), 1);
    check("async rst locked",  int'(locked),  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send_frame(512);
      check_model($sformatf("relock%0d", i));
    end
    check("relock updates", cnt_upd, 7);

    // Enable dropped on the frame start that would confirm a new code
    send_frame(256);
    send_frame(256);
    check_model("pre_disable");
    send_frame_disable(256);
    check("disable locked",  int'(locked),  0);
    check("disable tdm_num", int'(tdm_num), 4);
    check("disable updates", cnt_upd,       7);
    check("disable errors",  cnt_err,       2);
    set_enable(1'b1);
    for (int i = 0; i < 3; i++) begin
      send_frame(256);
      check_model($sformatf("reenable%0d", i));
    end
    check("reenable tdm_num", int'(tdm_num), 3);

    // Randomized frame lengths against the model
    len = 64;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 99) >= 55) len = lens[$urandom_range(0, 5)];
      send_frame(len);
      check_model($sformatf("rand%0d len%0d", i, len));
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_num_detector.md
# tdm_num_detector

Measures the TDM frame length of an incoming I2S/TDM stream and reports it as a slot-count register code. The code uses the same encoding the configuration registers use for `tdm_num`: 1=2 slots, 2=4, 3=8, 4=16. It sits in the I2S receive path, runs on the system clock, and oversamples the external BCLK/LRCK pins. Its output can be compared against, or loaded into, the configured `tdm_num` to auto-detect the link format.

## Interface
Parameters:
- `SLOT_BITS`, 32: BCLK cycles per slot. Legal values are 16, 24 or 32.
- `LOCK_FRAMES`, 2: consecutive identical valid frames required before the result is reported. Range 1..15.

Ports:
- `clk`  input  1  system clock. Frequency must be at least 4× the BCLK frequency.
- `rst_n`  input  1  asynchronous active-low reset.
- `i2s_bclk`  input  1  external bit clock. Asynchronous to `clk`.
- `i2s_lrck`  input  1  external frame sync. Asynchronous to `clk`. Its rising edge marks frame start.
- `enable`  input  1  detector enable, synchronous to `clk`.
- `tdm_num`  output  4  detected slot code, 1..4.
- `locked`  output  1  high while `tdm_num` reflects the current stream.
- `update`  output  1  one-cycle pulse when `tdm_num` is newly written, or re-confirmed after loss of lock.
- `err`  output  1  one-cycle pulse on an invalid frame length or a timeout.

## Operation
- Synchronization:
  - `i2s_bclk` and `i2s_lrck` each pass through a 2-flop synchronizer.
  - A third flop on BCLK provides edge detection.
  - A "bclk_rise" event is a cycle where the synced BCLK is 1 and its delayed copy is 0.
- On each bclk_rise, the synced LRCK is sampled into `lr_prev`.
- "frame_start" is a bclk_rise where the sampled LRCK is 1 and `lr_prev` is 0.
- `bit_cnt`, 10 bits:
  - Set to 1 on frame_start.
  - Incremented on every other bclk_rise.
  - Saturates at 1023.
  - On frame_start, the value before the reset is `frame_len`.
- Classification of `frame_len`:
  - 2·SLOT_BITS → code 1.
  - 4·SLOT_BITS → code 2.
  - 8·SLOT_BITS → code 3.
  - 16·SLOT_BITS → code 4.
  - Any other value is invalid.
- States:
  - IDLE:
    - Entered when `enable`=0; `enable` low forces IDLE from any state on the next cycle.
    - `bit_cnt`, candidate and `match_cnt` are cleared.
    - `locked`=0; `tdm_num` holds its value.
    - `enable`=1 → SEARCH.
  - SEARCH: waits for the first frame_start. No classification is done on it. → MEASURE.
  - MEASURE:
    - On frame_start with a valid code:
      - If code equals candidate, `match_cnt`++ (saturating at LOCK_FRAMES).
      - Otherwise candidate=code and `match_cnt`=1.
    - When `match_cnt` reaches LOCK_FRAMES, either of two conditions writes `tdm_num`=code, sets `locked`=1 and pulses `update` once: `locked`=0, or code≠`tdm_num`.
    - `match_cnt` stays saturated. Further identical frames produce no pulse.
    - While `locked`=1, a differing but valid frame does not clear `locked`. The old code stays reported until the new code is confirmed.
    - On frame_start with an invalid code:
      - `err` pulses.
      - `locked`=0 and `match_cnt`=0.
      - `tdm_num` holds.
      - State stays MEASURE.
    - Timeout: when `bit_cnt` reaches 1023 with no frame_start:
      - `err` pulses once.
      - `locked`=0.
      - State → SEARCH.
- Simultaneous events: `enable` falling takes priority over any frame_start processed in the same cycle. No `update` or `err` is issued in that cycle.

## Timing
- Reset values: `tdm_num`=4'd1, `locked`=0, `update`=0, `err`=0. State is IDLE and all counters are 0.
- Reset is asynchronous: outputs take their reset values immediately on `rst_n` falling, including mid-frame.
- Latency:
  - A BCLK pin edge becomes a bclk_rise 3 `clk` edges later (2 sync stages plus the delay flop).
  - `tdm_num`, `locked`, `update` and `err` are registered and change on the `clk` edge after the frame_start cycle.
- `update` and `err` are exactly one `clk` cycle wide and never assert in the same cycle.
- LRCK must be stable for at least one BCLK period around the sampling edge. This follows from the 4× clock-ratio requirement.

## Test plan
- 8 slots with SLOT_BITS=32 and LOCK_FRAMES=2: 256-BCLK frames.
  - The third LRCK rise yields `tdm_num`=3, `locked`=1 and a single `update` pulse.
  - Ten further identical frames produce no further pulses.
- While locked at 3, switch to 512-BCLK frames: after the second 512-BCLK frame, `tdm_num`=4 and `update` pulses once. `locked` stays 1 throughout.
- While locked at 3, inject one 100-BCLK frame: `err` pulses once, `locked`=0, `tdm_num` stays 3. Two following 256-BCLK frames restore `locked`=1 with an `update` pulse.
- Stop LRCK while BCLK keeps running: after 1023 BCLK rises since the last frame start, `err` pulses once, `locked`=0 and the FSM returns to SEARCH. No further `err` occurs until frames resume.
- Assert `rst_n`=0 mid-frame while locked at 4: `tdm_num` goes to 1 and `locked` to 0 asynchronously. After release, relock needs SEARCH plus LOCK_FRAMES valid frames.
- Deassert `enable` while locked, during a frame_start cycle: `locked`=0 with no `update` or `err`. `tdm_num` holds. Re-enabling relocks after 3 valid frames.
